// File: rtl/vt52_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vt52_pkg : shared constants, FSM encoding and baud divisor table.   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package vt52_pkg;

  localparam int OVS   = 16;
  localparam int DIV_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Clocks per oversampling tick at 50 MHz, indexed by the 3-bit speed code.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code);
    logic [DIV_W-1:0] d;
    case (code)
      3'd0:    d = 12'd2604;
      3'd1:    d = 12'd1302;
      3'd2:    d = 12'd651;
      3'd3:    d = 12'd326;
      3'd4:    d = 12'd163;
      3'd5:    d = 12'd81;
      3'd6:    d = 12'd54;
      default: d = 12'd27;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vt52_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vt52_baud_tick : 16x oversampling tick divider with speed-change     |
// | detection and a synchronous clear. Revision 1.0                      |
// +----------------------------------------------------------------------+
module vt52_baud_tick
  import vt52_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] speed_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic       spd_chg_o
);

  logic [2:0]       speed_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] w_div_last;

  assign w_div_last = baud_div(speed_q) - 12'd1;
  assign spd_chg_o  = (speed_i != speed_q);
  assign tick_o     = (cnt_q == w_div_last);

  always_comb begin
    cnt_d = cnt_q + 12'd1;
    if (clr_i || spd_chg_o || tick_o) begin
      cnt_d = '0;
    end
  end

  // Loading the live code in reset keeps the first cycle out of reset from
  // looking like a speed change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      speed_q <= speed_i;
      cnt_q   <= '0;
    end else begin
      speed_q <= speed_i;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vt52_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vt52_uart_rx : 8N1 UART receiver, 16x oversampled, with a single-    |
// | entry valid/ack holding register. Revision 1.0                       |
// +----------------------------------------------------------------------+
module vt52_uart_rx
  import vt52_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int OVS    = 16
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [2:0] speed,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_ferr,
  output logic       rx_ovr,
  output logic       rx_busy
);

  localparam int              TC_W    = $clog2(OVS);
  localparam logic [TC_W-1:0] TC_S1   = TC_W'(OVS / 2 - 1);
  localparam logic [TC_W-1:0] TC_S2   = TC_W'(OVS / 2);
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVS / 2 + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVS - 1);

  if (CLK_HZ != 50000000 || OVS != vt52_pkg::OVS) begin : g_cfg_guard
    $error("vt52_uart_rx: divisor table is fixed for 50 MHz and 16x oversampling");
  end

  logic            rx_meta_q;
  logic            rxs_q;
  logic            rxs_prev_q;
  rx_state_e       state_q;
  logic [TC_W-1:0] tc_q;
  logic [2:0]      bit_q;
  logic [1:0]      smp_q;
  logic [7:0]      shift_q;
  logic            done_q;
  logic            ferr_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            ovr_q;

  logic            w_tick;
  logic            w_spd_chg;
  logic            w_fall;
  logic            w_clr;
  logic            w_maj;
  logic            w_in_frame;

  always_ff @(posedge clk50) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign w_fall     = rxs_prev_q & ~rxs_q;
  assign w_clr      = (state_q == ST_IDLE) & w_fall;
  assign w_in_frame = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  // Third vote is the live synchronised sample on the deciding tick.
  assign w_maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

  vt52_baud_tick u_baud_tick (
    .clk_i     (clk50),
    .rst_i     (reset),
    .speed_i   (speed),
    .clr_i     (w_clr),
    .tick_o    (w_tick),
    .spd_chg_o (w_spd_chg)
  );

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tc_q    <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (w_spd_chg) begin
        state_q <= ST_IDLE;
        tc_q    <= '0;
      end else begin
        if (w_tick && w_in_frame) begin
          tc_q <= tc_q + 1'b1;
          if (tc_q == TC_S1) smp_q[0] <= rxs_q;
          if (tc_q == TC_S2) smp_q[1] <= rxs_q;
        end
        case (state_q)
          ST_IDLE: begin
            if (w_fall) begin
              state_q <= ST_START;
              tc_q    <= '0;
            end
          end
          ST_START: begin
            if (w_tick) begin
              if (tc_q == TC_MID && w_maj) begin
                state_q <= ST_IDLE;
              end else if (tc_q == TC_LAST) begin
                state_q <= ST_DATA;
                bit_q   <= '0;
              end
            end
          end
          ST_DATA: begin
            if (w_tick) begin
              if (tc_q == TC_MID) shift_q <= {w_maj, shift_q[7:1]};
              if (tc_q == TC_LAST) begin
                if (bit_q == 3'd7) state_q <= ST_STOP;
                else               bit_q   <= bit_q + 3'd1;
              end
            end
          end
          ST_STOP: begin
            // Returning to IDLE mid-stop lets a back-to-back start edge be caught.
            if (w_tick && tc_q == TC_MID) begin
              if (w_maj) begin
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (rxs_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (done_q) begin
      data_q  <= shift_q;
      valid_q <= 1'b1;
      if (valid_q) ovr_q <= ~rx_ack;
    end else if (valid_q && rx_ack) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  assign rx_ovr   = ovr_q;
  assign rx_busy  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vt52_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vt52_uart_rx : directed and randomised frames against a byte-     |
// | level model of the receiver's holding register. Revision 1.0         |
// +----------------------------------------------------------------------+
module tb_vt52_uart_rx;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [2:0] speed;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_ovr;
  logic       rx_busy;

  int n_chk    = 0;
  int n_pass   = 0;
  int ferr_cnt = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  vt52_uart_rx #(.CLK_HZ(50000000), .OVS(16)) dut (
    .clk50    (clk50),
    .reset    (reset),
    .speed    (speed),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_ferr  (rx_ferr),
    .rx_ovr   (rx_ovr),
    .rx_busy  (rx_busy)
  );

  always #10 clk50 = ~clk50;

  always @(negedge clk50) if (rx_ferr === 1'b1) ferr_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Nominal line bit time in 50 MHz clocks for each speed code.
  function automatic int bit_cycles(input logic [2:0] sp);
    case (sp)
      3'd0:    return 41667;
      3'd1:    return 20833;
      3'd2:    return 10417;
      3'd3:    return 5208;
      3'd4:    return 2604;
      3'd5:    return 1302;
      3'd6:    return 868;
      default: return 434;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic m_complete(input logic [7:0] b);
    if (m_valid) m_ovr = 1'b1;
    m_data  = b;
    m_valid = 1'b1;
  endtask

  task automatic m_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "/valid"}, 32'(rx_valid), 32'(m_valid));
    chk({tag, "/data"},  32'(rx_data),  32'(m_data));
    chk({tag, "/ovr"},   32'(rx_ovr),   32'(m_ovr));
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    m_ack();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    rx = 1'b0;
    step(n);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(n);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int n);
    send_bits(b, n);
    rx = 1'b1;
    step(n);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    int         n;
    int         f0;
    bit         ok;
    logic [7:0] rb;

    rx = 1'b1; rx_ack = 1'b0; speed = 3'd7; reset = 1'b1;
    m_reset();
    step(5);
    chk_hold("reset");
    chk("reset/ferr", 32'(rx_ferr), 32'd0);
    chk("reset/busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    step(10);

    // 0x55 at 115200: nothing before the stop bit is judged, byte after it
    n  = bit_cycles(3'd7);
    f0 = ferr_cnt;
    send_bits(8'h55, n);
    rx = 1'b1;
    step(n / 2);
    chk("t1/early_valid", 32'(rx_valid), 32'd0);
    step(n - n / 2);
    m_complete(8'h55);
    chk_hold("t1");
    chk("t1/ferr", 32'(ferr_cnt), 32'(f0));
    do_ack();
    chk_hold("t1_ack");

    // back-to-back frames, each acked before the next completes
    step(20);
    fork
      begin
        send_frame(8'hA3, n);
        send_frame(8'h0F, n);
      end
      begin
        wait_valid(12 * n, ok);
        chk("t2/first_seen", 32'(ok), 32'd1);
        m_complete(8'hA3);
        chk_hold("t2_first");
        do_ack();
        chk("t2/ack_clears", 32'(rx_valid), 32'd0);
        wait_valid(12 * n, ok);
        chk("t2/second_seen", 32'(ok), 32'd1);
        m_complete(8'h0F);
        chk_hold("t2_second");
      end
    join
    do_ack();
    chk_hold("t2_ack");

    // 20 us glitch at 9600 is a false start
    speed = 3'd3;
    step(20);
    f0 = ferr_cnt;
    rx = 1'b0;
    step(500);
    chk("t3/busy_in_glitch", 32'(rx_busy), 32'd1);
    step(500);
    rx = 1'b1;
    step(4000);
    chk("t3/busy", 32'(rx_busy), 32'd0);
    chk_hold("t3");
    chk("t3/ferr", 32'(ferr_cnt), 32'(f0));

    // framing error, held break, then recovery
    speed = 3'd7;
    step(20);
    f0 = ferr_cnt;
    send_bits(8'hC4, n);
    rx = 1'b0;
    step(21 * n);
    chk("t4/ferr_pulses", 32'(ferr_cnt), 32'(f0 + 1));
    chk("t4/no_valid", 32'(rx_valid), 32'd0);
    chk("t4/break_busy", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    step(5);
    chk("t4/idle_after_break", 32'(rx_busy), 32'd0);
    send_frame(8'h31, n);
    m_complete(8'h31);
    chk_hold("t4_recover");
    chk("t4/ferr_after", 32'(ferr_cnt), 32'(f0 + 1));
    do_ack();

    // overrun: two bytes without ack
    speed = 3'd6;
    step(20);
    n = bit_cycles(3'd6);
    send_frame(8'h11, n);
    m_complete(8'h11);
    send_frame(8'h22, n);
    m_complete(8'h22);
    chk_hold("t5_ovr");
    do_ack();
    chk_hold("t5_ack");

    // reset in the middle of bit 4 of 0x7E
    speed = 3'd7;
    n = bit_cycles(3'd7);
    step(20);
    f0 = ferr_cnt;
    rb = 8'h7E;
    rx = 1'b0;
    step(n);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      step(n);
    end
    rx = rb[4];
    step(n / 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    m_reset();
    chk_hold("t6_reset");
    chk("t6/reset_busy", 32'(rx_busy), 32'd0);
    rx = 1'b1;
    step(2 * n);
    chk_hold("t6_quiet");
    rb = 8'($urandom);
    send_frame(rb, n);
    m_complete(rb);
    chk_hold("t6_after_reset");
    chk("t6/ferr", 32'(ferr_cnt), 32'(f0));
    do_ack();

    // speed change mid-frame aborts silently
    step($urandom_range(1, 200));
    rb = 8'($urandom);
    rx = 1'b0;
    step(n);
    for (int i = 0; i < 3; i++) begin
      rx = rb[i];
      step(n);
    end
    step(n / 2);
    speed = 3'd3;
    step(2);
    chk("t7/abort_busy", 32'(rx_busy), 32'd0);
    rx = 1'b1;
    step(n);
    speed = 3'd7;
    step(2 * n);
    chk_hold("t7_abort");
    chk("t7/ferr", 32'(ferr_cnt), 32'(f0));
    rb = 8'($urandom);
    send_frame(rb, n);
    m_complete(rb);
    chk_hold("t7_after_change");
    do_ack();

    // one more random byte with a random gap and a late ack
    step($urandom_range(1, 300));
    rb = 8'($urandom);
    send_frame(rb, n);
    m_complete(rb);
    step($urandom_range(0, 50));
    chk_hold("t8_random");
    do_ack();
    chk_hold("t8_ack");
    chk("t8/busy", 32'(rx_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
